snake_body_engine: RTL and testbench
====================================

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum segment count including the head.
REQ-002 SHALL have parameter STEP, default 20, head displacement per move in pixels.
REQ-003 SHALL have parameter SEG, default 16, segment square side in pixels.
REQ-004 SHALL have parameters FIELD_W and FIELD_H, defaults 640 and 480, playfield size in pixels.
REQ-005 SHALL have parameters START_X and START_Y, defaults 320 and 240, head position after reset.
REQ-006 SHALL have port clk, input, width 1, the single clock.
REQ-007 SHALL have port rst, input, width 1, reset; synchronous to clk and active-high.
REQ-008 SHALL have port step, input, width 1, one-cycle move request.
REQ-009 SHALL have port dir, input, width 2, direction: 00 up, 01 left, 10 down, 11 right.
REQ-010 SHALL have port dir_valid, input, width 1, qualifies dir.
REQ-011 SHALL have port grow, input, width 1, one-cycle growth request.
REQ-012 SHALL have ports pix_x and pix_y, inputs, width 11 each, raster probe coordinates.
REQ-013 SHALL have ports head_x and head_y, outputs, width 11 each, current head position.
REQ-014 SHALL have port length, output, width $clog2(MAX_LEN+1), active segment count.
REQ-015 SHALL have ports pix_head and pix_body, outputs, width 1 each, probe hits head or body.
REQ-016 SHALL have ports collide, wall_hit, busy and full, outputs, width 1 each.

Function
REQ-017 SHALL hold segment registers seg[0..MAX_LEN-1], where seg[0] is the head; only seg[0..length-1] are active.
REQ-018 SHALL latch dir on dir_valid, except when dir is the reverse of the last committed direction, in which case it is ignored.
REQ-019 SHALL latch grow into a pending flag; the pending flag is ignored while full=1 (full = length==MAX_LEN).
REQ-020 SHALL accept step only when busy=0, collide=0 and wall_hit=0; otherwise step is dropped.
REQ-021 SHALL use an FSM with states IDLE, SHIFT and SCAN; an accepted step moves IDLE->SHIFT.
REQ-022 SHALL, in SHIFT (one cycle), do the following: seg[i]<=seg[i-1] for i>=1; move the head by STEP along the committed direction; if grow is pending, set length+1 and clear the pending flag.
REQ-023 SHALL, in SCAN, compare seg[k] against the head for k=1..length-1, one segment per cycle; on a match, set collide (sticky); return to IDLE after the last k.
REQ-024 SHALL skip SCAN when length==1 (SHIFT->IDLE).
REQ-025 SHALL hold busy=1 in SHIFT and SCAN, i.e. for exactly length cycles after step is accepted.
REQ-026 SHALL, when dir_valid and step arrive in the same cycle, apply the new dir to that step.
REQ-027 SHALL, when grow and step arrive in the same cycle, apply the growth to that step.
REQ-028 SHALL register pix_head and pix_body with 1-cycle latency, using inclusive bounds [x, x+SEG-1] and [y, y+SEG-1]; pix_body covers seg[1..length-1]; both are valid regardless of busy.
REQ-029 SHALL perform all coordinate arithmetic in 11 bits with no negative intermediate values; the in-field range is 0..FIELD_W-STEP and 0..FIELD_H-STEP.

Reset
REQ-030 SHALL, on rst: set all seg to (START_X, START_Y); length=1; committed dir=right; clear pending grow; collide=0, wall_hit=0, busy=0, pix_head=0, pix_body=0; state IDLE.
REQ-031 SHALL, on rst mid-SHIFT or mid-SCAN, abort the operation and apply REQ-030 on the next edge.

Configuration
REQ-032 SHALL support macro SNAKE_WRAP_EN; when defined, the head wraps at field edges (left from 0 -> FIELD_W-STEP, right from FIELD_W-STEP -> 0, same rule for y) and wall_hit is tied to 0.
REQ-033 SHALL, when SNAKE_WRAP_EN is undefined, block any move leaving the field: the head holds, no shift occurs, and wall_hit is set (sticky until rst).

Verification
REQ-034 SHALL cover: rst, then 3 steps with no dir -> head=(380,240), length=1, busy high 1 cycle per step.
REQ-035 SHALL cover: grow+step three times -> length=4; the next step -> busy high 4 cycles.
REQ-036 SHALL cover: committed right, dir_valid with dir=01 (left), then step -> left ignored, head_x+20.
REQ-037 SHALL cover: length=5 moving right, then steps down, left, up -> collide=1 at the end of SCAN; later steps leave head unchanged.
REQ-038 SHALL cover: 15 steps right from reset -> head_x=620; 16th step without macro -> wall_hit=1, head_x=620; with macro -> head_x=0, wall_hit=0.
REQ-039 SHALL cover: head at (320,240), probe (335,255) -> pix_head=1 one cycle later; probe (336,240) -> pix_head=0.

Source files
------------

// File: rtl/snake_body_engine.sv
// Snake body engine: segment shift register, sequential self-collision scan and raster probe.
// Define SNAKE_WRAP_EN to wrap the head at the field edges instead of stopping at the walls.
module snake_body_engine #(
  parameter int MAX_LEN = 16,
  parameter int STEP    = 20,
  parameter int SEG     = 16,
  parameter int FIELD_W = 640,
  parameter int FIELD_H = 480,
  parameter int START_X = 320,
  parameter int START_Y = 240
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step,
  input  logic [1:0]                   dir,
  input  logic                         dir_valid,
  input  logic                         grow,
  input  logic [10:0]                  pix_x,
  input  logic [10:0]                  pix_y,
  output logic [10:0]                  head_x,
  output logic [10:0]                  head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         pix_head,
  output logic                         pix_body,
  output logic                         collide,
  output logic                         wall_hit,
  output logic                         busy,
  output logic                         full
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int KW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [10:0] STEP_V = 11'(STEP);
  localparam logic [10:0] SEG_M1 = 11'(SEG - 1);
  localparam logic [10:0] X_LAST = 11'(FIELD_W - STEP);
  localparam logic [10:0] Y_LAST = 11'(FIELD_H - STEP);
  localparam logic [10:0] X_INIT = 11'(START_X);
  localparam logic [10:0] Y_INIT = 11'(START_Y);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, SCAN} state_t;

  state_t         state, state_n;
  logic [10:0]    seg_x [MAX_LEN];
  logic [10:0]    seg_y [MAX_LEN];
  logic [1:0]     dir_q;
  logic           grow_pend;
  logic           collide_q;
  logic [KW-1:0]  scan_k;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  new_len;
  logic [10:0]    nx, ny;
  logic           blocked;
  logic           grow_now;
  logic           scan_last;
  logic           step_ok;
  logic           head_hit;
  logic           body_hit;
`ifndef SNAKE_WRAP_EN
  logic           wall_q;
`endif

  function automatic logic in_box(input logic [10:0] sx, input logic [10:0] sy,
                                  input logic [10:0] px, input logic [10:0] py);
    return (px >= sx) && (px <= sx + SEG_M1) && (py >= sy) && (py <= sy + SEG_M1);
  endfunction

  assign head_x   = seg_x[0];
  assign head_y   = seg_y[0];
  assign length   = len_q;
  assign collide  = collide_q;
  assign busy     = (state != IDLE);
  assign full     = (len_q == LW'(MAX_LEN));
  assign grow_now = grow_pend && !full;
  assign new_len  = len_q + LW'(grow_now);
  assign scan_last = ((LW'(scan_k) + LW'(1)) == len_q);
  assign step_ok  = step && !collide_q && !wall_hit;

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = wall_q;
`endif

  // Candidate head position; unsigned compares keep every intermediate non-negative.
  always_comb begin
    nx      = seg_x[0];
    ny      = seg_y[0];
    blocked = 1'b0;
    case (dir_q)
      DIR_UP: begin
        if (seg_y[0] < STEP_V) begin
`ifdef SNAKE_WRAP_EN
          ny = Y_LAST;
`else
          blocked = 1'b1;
`endif
        end else begin
          ny = seg_y[0] - STEP_V;
        end
      end
      DIR_LEFT: begin
        if (seg_x[0] < STEP_V) begin
`ifdef SNAKE_WRAP_EN
          nx = X_LAST;
`else
          blocked = 1'b1;
`endif
        end else begin
          nx = seg_x[0] - STEP_V;
        end
      end
      DIR_DOWN: begin
        if (seg_y[0] + STEP_V > Y_LAST) begin
`ifdef SNAKE_WRAP_EN
          ny = 11'd0;
`else
          blocked = 1'b1;
`endif
        end else begin
          ny = seg_y[0] + STEP_V;
        end
      end
      default: begin
        if (seg_x[0] + STEP_V > X_LAST) begin
`ifdef SNAKE_WRAP_EN
          nx = 11'd0;
`else
          blocked = 1'b1;
`endif
        end else begin
          nx = seg_x[0] + STEP_V;
        end
      end
    endcase
  end

  always_comb begin
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) && in_box(seg_x[i], seg_y[i], pix_x, pix_y)) begin
        body_hit = 1'b1;
      end
    end
    head_hit = in_box(seg_x[0], seg_y[0], pix_x, pix_y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A blocked move or a single-segment snake has nothing to scan.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (step_ok) state_n = SHIFT;
      SHIFT:   state_n = (blocked || (new_len == LW'(1))) ? IDLE : SCAN;
      SCAN:    if (scan_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_INIT;
        seg_y[i] <= Y_INIT;
      end
      len_q     <= LW'(1);
      dir_q     <= DIR_RIGHT;
      grow_pend <= 1'b0;
      collide_q <= 1'b0;
      scan_k    <= KW'(1);
      pix_head  <= 1'b0;
      pix_body  <= 1'b0;
`ifndef SNAKE_WRAP_EN
      wall_q    <= 1'b0;
`endif
    end else begin
      // Reversal is judged against the latched direction, so a dir arriving with step steers that step.
      if (dir_valid && (dir != (dir_q ^ 2'b10))) begin
        dir_q <= dir;
      end

      if ((state == SHIFT) && !blocked && grow_now) begin
        grow_pend <= 1'b0;
      end
      if (grow && !full) begin
        grow_pend <= 1'b1;
      end

      if (state == SHIFT) begin
        if (blocked) begin
`ifndef SNAKE_WRAP_EN
          wall_q <= 1'b1;
`endif
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          len_q    <= new_len;
          scan_k   <= KW'(1);
        end
      end

      if (state == SCAN) begin
        if ((seg_x[scan_k] == seg_x[0]) && (seg_y[scan_k] == seg_y[0])) begin
          collide_q <= 1'b1;
        end
        scan_k <= scan_k + KW'(1);
      end

      pix_head <= head_hit;
      pix_body <= body_hit;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed self-checking bench for snake_body_engine; expectations are hand-computed
// for the default parameters, with the wall case switching on SNAKE_WRAP_EN.
module tb_snake_body_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [1:0]  dir;
  logic        dir_valid;
  logic        grow;
  logic [10:0] pix_x, pix_y;
  logic [10:0] head_x, head_y;
  logic [4:0]  length;
  logic        pix_head, pix_body, collide, wall_hit, busy, full;

  int checks   = 0;
  int failures = 0;
  int cyc;

  snake_body_engine dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .dir_valid(dir_valid), .grow(grow),
    .pix_x(pix_x), .pix_y(pix_y), .head_x(head_x), .head_y(head_y), .length(length),
    .pix_head(pix_head), .pix_body(pix_body), .collide(collide), .wall_hit(wall_hit),
    .busy(busy), .full(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Holds the given inputs across one rising edge, then returns them to idle at the next falling edge.
  task automatic applyStimulus(input logic s, input logic [1:0] d, input logic dv, input logic g);
    step = s; dir = d; dir_valid = dv; grow = g;
    @(negedge clk);
    step = 1'b0; dir_valid = 1'b0; grow = 1'b0;
  endtask

  task automatic doStep(input logic [1:0] d, input logic dv, input logic g, output int cycles);
    applyStimulus(1'b1, d, dv, g);
    cycles = 0;
    while ((busy === 1'b1) && (cycles < 64)) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; dir = 2'b00; dir_valid = 1'b0; grow = 1'b0;
    pix_x = 11'd0; pix_y = 11'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_head_x", head_x, 320);
    checkOutput("rst_head_y", head_y, 240);
    checkOutput("rst_length", length, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_collide", collide, 0);
    checkOutput("rst_wall", wall_hit, 0);
    checkOutput("rst_pix_head", pix_head, 0);
    checkOutput("rst_pix_body", pix_body, 0);
    rst = 1'b0;

    // Three plain steps along the reset direction.
    for (int i = 0; i < 3; i++) begin
      doStep(2'b00, 1'b0, 1'b0, cyc);
      checkOutput("plain_busy_cycles", cyc, 1);
    end
    checkOutput("plain_head_x", head_x, 380);
    checkOutput("plain_head_y", head_y, 240);
    checkOutput("plain_length", length, 1);

    // A reversal to the left must be ignored.
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
    doStep(2'b00, 1'b0, 1'b0, cyc);
    checkOutput("reverse_head_x", head_x, 400);
    checkOutput("reverse_head_y", head_y, 240);

    // Probe latency and inclusive box edges around (320,240).
    doReset();
    pix_x = 11'd335; pix_y = 11'd255;
    #1;
    checkOutput("probe_not_yet", pix_head, 0);
    @(negedge clk);
    checkOutput("probe_corner_head", pix_head, 1);
    checkOutput("probe_corner_body", pix_body, 0);
    pix_x = 11'd336; pix_y = 11'd240;
    @(negedge clk);
    checkOutput("probe_outside_x", pix_head, 0);
    pix_x = 11'd320; pix_y = 11'd256;
    @(negedge clk);
    checkOutput("probe_outside_y", pix_head, 0);
    pix_x = 11'd0; pix_y = 11'd0;

    // Growth applied on the same step, busy equals the new length.
    doReset();
    for (int i = 0; i < 3; i++) begin
      doStep(2'b00, 1'b0, 1'b1, cyc);
      checkOutput("grow_busy_cycles", cyc, i + 2);
    end
    checkOutput("grow_length", length, 4);
    checkOutput("grow_head_x", head_x, 380);
    doStep(2'b00, 1'b0, 1'b0, cyc);
    checkOutput("len4_busy_cycles", cyc, 4);
    checkOutput("len4_head_x", head_x, 400);
    checkOutput("len4_full", full, 0);
    pix_x = 11'd345; pix_y = 11'd245;
    @(negedge clk);
    @(negedge clk);
    checkOutput("probe_tail_body", pix_body, 1);
    checkOutput("probe_tail_head", pix_head, 0);
    pix_x = 11'd0; pix_y = 11'd0;

    // Reset in the middle of a scan aborts the move.
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midscan_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midscan_rst_head_x", head_x, 320);
    checkOutput("midscan_rst_length", length, 1);
    checkOutput("midscan_rst_busy", busy, 0);
    rst = 1'b0;

    // Length 5 heading right, then down/left/up curls the head onto its own tail.
    doReset();
    for (int i = 0; i < 4; i++) begin
      doStep(2'b00, 1'b0, 1'b1, cyc);
    end
    checkOutput("coil_length", length, 5);
    checkOutput("coil_head_x", head_x, 400);
    doStep(2'b10, 1'b1, 1'b0, cyc);
    checkOutput("coil_down_head_y", head_y, 260);
    checkOutput("coil_down_collide", collide, 0);
    doStep(2'b01, 1'b1, 1'b0, cyc);
    checkOutput("coil_left_head_x", head_x, 380);
    doStep(2'b00, 1'b1, 1'b0, cyc);
    checkOutput("coil_up_busy_cycles", cyc, 5);
    checkOutput("coil_up_head_y", head_y, 240);
    checkOutput("coil_collide", collide, 1);
    doStep(2'b00, 1'b0, 1'b0, cyc);
    checkOutput("dead_busy_cycles", cyc, 0);
    checkOutput("dead_head_x", head_x, 380);
    checkOutput("dead_head_y", head_y, 240);

    // Run into the right wall.
    doReset();
    for (int i = 0; i < 15; i++) begin
      doStep(2'b00, 1'b0, 1'b0, cyc);
    end
    checkOutput("edge_head_x", head_x, 620);
    checkOutput("edge_wall", wall_hit, 0);
    doStep(2'b00, 1'b0, 1'b0, cyc);
    checkOutput("wall_step_busy", cyc, 1);
`ifdef SNAKE_WRAP_EN
    checkOutput("wrap_head_x", head_x, 0);
    checkOutput("wrap_wall", wall_hit, 0);
    doStep(2'b00, 1'b0, 1'b0, cyc);
    checkOutput("wrap_next_busy", cyc, 1);
    checkOutput("wrap_next_head_x", head_x, 20);
`else
    checkOutput("wall_head_x", head_x, 620);
    checkOutput("wall_flag", wall_hit, 1);
    doStep(2'b01, 1'b1, 1'b0, cyc);
    checkOutput("wall_dropped_busy", cyc, 0);
    checkOutput("wall_dropped_head_x", head_x, 620);
`endif
    checkOutput("wall_head_y", head_y, 240);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
